// File: rtl/clarke_frontend.sv
// clarke_frontend: phase-current front end ahead of the Park stage.
// Removes per-phase zero-current offsets, found by a calibration FSM that
// averages 2^CAL_LOG2 raw samples per phase. The corrected (ia, ib) pair then
// goes through a 3-stage Clarke transform pipeline that yields alpha/beta.
//   alpha = ia_c
//   beta  = (ia_c + 2*ib_c) / sqrt(3)
module clarke_frontend #(
  parameter int W             = 16,
  parameter int CAL_LOG2      = 6,
  parameter int INV_SQRT3_Q15 = 18919
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cal_start,
  input  logic                in_valid,
  input  logic signed [W-1:0] ia,
  input  logic signed [W-1:0] ib,
  output logic                out_valid,
  output logic signed [W-1:0] alpha,
  output logic signed [W-1:0] beta,
  output logic                cal_busy,
  output logic                cal_done,
  output logic signed [W-1:0] offset_a,
  output logic signed [W-1:0] offset_b
);

  // Accumulator wide enough for 2^CAL_LOG2 full-scale samples without overflow
  localparam int AW = W + CAL_LOG2;
  // Stage-2 product width
  localparam int PW = 2 * W + 2;
  // Sum width for ia_c + 2*ib_c
  localparam int SW = W + 2;

  localparam logic signed [PW-1:0] K_INV_SQRT3 = PW'(INV_SQRT3_Q15);
  localparam logic signed [PW-1:0] ROUND_HALF  = PW'(1 << 14);
  localparam logic [CAL_LOG2-1:0]  CNT_ONE     = CAL_LOG2'(1);

  localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {
    RUN = 1'b0,
    CAL = 1'b1
  } state_t;

  state_t state, state_next;

  logic signed [AW-1:0]     acc_a, acc_b;
  logic signed [AW-1:0]     acc_a_next, acc_b_next;
  logic signed [AW-1:0]     acc_a_sum, acc_b_sum;
  logic [CAL_LOG2-1:0]      cnt, cnt_next;
  logic signed [W-1:0]      off_a_next, off_b_next;
  logic                     done_next;

  logic                     accept;
  logic signed [W:0]        diff_a, diff_b;

  logic                     s1_valid;
  logic signed [W-1:0]      s1_ia, s1_ib;
  logic signed [SW-1:0]     s_sum;
  logic signed [PW-1:0]     p_calc;

  logic                     s2_valid;
  logic signed [W-1:0]      s2_ia;
  logic signed [PW-1:0]     s2_p;
  logic signed [PW-1:0]     p_rounded;
  logic signed [W-1:0]      beta_sat;

  // Clamp a (W+1)-bit difference back into W bits; overflow shows as the top
  // two bits disagreeing.
  function automatic logic signed [W-1:0] sat_diff(input logic signed [W:0] x);
    logic signed [W-1:0] r;
    if (x[W] != x[W-1]) begin
      r = x[W] ? W_MIN : W_MAX;
    end else begin
      r = x[W-1:0];
    end
    return r;
  endfunction

  // Clamp a product-width value into W bits; it fits only when every bit
  // from the W-1 position upward equals the sign bit.
  function automatic logic signed [W-1:0] sat_prod(input logic signed [PW-1:0] x);
    logic signed [W-1:0] r;
    logic [PW-W:0]       top;
    top = x[PW-1:W-1];
    if ((top == '0) || (top == '1)) begin
      r = x[W-1:0];
    end else begin
      r = x[PW-1] ? W_MIN : W_MAX;
    end
    return r;
  endfunction

  assign acc_a_sum = acc_a + AW'(ia);
  assign acc_b_sum = acc_b + AW'(ib);

  // Calibration FSM next-state logic: arm on cal_start, accumulate raw samples,
  // latch averaged offsets on the final sample.
  always_comb begin
    state_next = state;
    acc_a_next = acc_a;
    acc_b_next = acc_b;
    cnt_next   = cnt;
    off_a_next = offset_a;
    off_b_next = offset_b;
    done_next  = 1'b0;
    case (state)
      RUN: begin
        if (cal_start) begin
          state_next = CAL;
          acc_a_next = '0;
          acc_b_next = '0;
          cnt_next   = '0;
        end
      end
      CAL: begin
        if (in_valid) begin
          acc_a_next = acc_a_sum;
          acc_b_next = acc_b_sum;
          cnt_next   = cnt + CNT_ONE;
          if (cnt == '1) begin
            state_next = RUN;
            off_a_next = W'(acc_a_sum >>> CAL_LOG2);
            off_b_next = W'(acc_b_sum >>> CAL_LOG2);
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Calibration state, accumulators, offsets and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      acc_a    <= '0;
      acc_b    <= '0;
      cnt      <= '0;
      offset_a <= '0;
      offset_b <= '0;
      cal_busy <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      state    <= state_next;
      acc_a    <= acc_a_next;
      acc_b    <= acc_b_next;
      cnt      <= cnt_next;
      offset_a <= off_a_next;
      offset_b <= off_b_next;
      cal_busy <= (state_next == CAL);
      cal_done <= done_next;
    end
  end

  // Samples only enter the pipeline while running; calibration samples are consumed by the FSM
  assign accept = in_valid && (state == RUN);
  assign diff_a = $signed({ia[W-1], ia}) - $signed({offset_a[W-1], offset_a});
  assign diff_b = $signed({ib[W-1], ib}) - $signed({offset_b[W-1], offset_b});

  // Stage 1: offset removal with saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ia    <= '0;
      s1_ib    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ia <= sat_diff(diff_a);
        s1_ib <= sat_diff(diff_b);
      end
    end
  end

  assign s_sum  = SW'(s1_ia) + (SW'(s1_ib) <<< 1);
  assign p_calc = PW'(s_sum) * K_INV_SQRT3;

  // Stage 2: scale ia_c + 2*ib_c by 1/sqrt(3) in Q15, forward ia_c
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_ia    <= '0;
      s2_p     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ia <= s1_ia;
        s2_p  <= p_calc;
      end
    end
  end

  assign p_rounded = (s2_p + ROUND_HALF) >>> 15;
  assign beta_sat  = sat_prod(p_rounded);

  // Stage 3: round-half-up and saturate beta; outputs hold between valid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alpha     <= '0;
      beta      <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        alpha <= s2_ia;
        beta  <= beta_sat;
      end
    end
  end

endmodule
